// File: rtl/adlv_pkg.sv
// adlv_pkg: shared state encoding, default widths and chunk-count helper for the adlv back end
package adlv_pkg;
  localparam int W_DEF = 19;
  localparam int CHUNK_DEF = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int nchunk(input int w, input int c);
    return (w + c - 1) / c;
  endfunction
endpackage

// File: rtl/adlv_chunk_add.sv
// adlv_chunk_add: CHUNK-bit a+b+cin producing sum and carry-out
module adlv_chunk_add #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout
);
  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_cin};
endmodule

// File: rtl/adlv_resolve.sv
// adlv_resolve: resolves a redundant (s,e) pair to binary CHUNK bits per cycle; ADLV_RESOLVE_BYPASS_EN enables the e==0 fast path
module adlv_resolve
  import adlv_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] s_in,
  input  logic [W-1:0] e_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   sum_out,
  output logic         busy
);
  localparam int NCHUNK = nchunk(W, CHUNK);
  localparam int PW     = NCHUNK * CHUNK;
  localparam int LASTN  = W - (NCHUNK - 1) * CHUNK;
  localparam int IW     = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  state_t           r_state;
  logic [PW-1:0]    r_s, r_e;
  logic             r_carry;
  logic [IW-1:0]    r_idx;
  logic [W:0]       r_res;
  logic [PW-1:0]    w_src_s, w_src_e;
  logic [IW-1:0]    w_idx;
  logic [CHUNK-1:0] w_sum;
  logic             w_cout, w_last, w_fin;
  logic [W:0]       w_res, w_next;
  assign w_src_s = r_state == IDLE ? PW'(s_in) : r_s;
  assign w_src_e = r_state == IDLE ? PW'(e_in) : r_e;
  assign w_idx   = r_state == IDLE ? '0 : r_idx;
  assign w_last  = w_idx == IW'(NCHUNK - 1);
  adlv_chunk_add #(.CHUNK(CHUNK)) u_add (
    .i_a   (CHUNK'(w_src_s >> (CHUNK * w_idx))),
    .i_b   (CHUNK'(w_src_e >> (CHUNK * w_idx))),
    .i_cin (r_state == RUN && r_carry),
    .o_sum (w_sum),
    .o_cout(w_cout)
  );
  for (genvar g = 0; g < W; g++) begin : g_bit
    assign w_res[g] = w_idx == IW'(g / CHUNK) ? w_sum[g % CHUNK] : r_res[g];
  end
  assign w_res[W] = w_last ? (LASTN == CHUNK ? w_cout : w_sum[LASTN % CHUNK]) : r_res[W];
`ifdef ADLV_RESOLVE_BYPASS_EN
  logic w_byp;
  assign w_byp  = r_state == IDLE && e_in == '0;
  assign w_fin  = w_last || w_byp;
  assign w_next = w_byp ? {1'b0, s_in} : w_res;
`else
  assign w_fin  = w_last;
  assign w_next = w_res;
`endif
  assign sum_out = r_res;
  // chunk 0 resolves on the accept edge, later chunks in RUN; DONE holds the result until taken
  always_ff @(posedge clk)
    if (rst) begin
      r_state   <= IDLE;
      r_s       <= '0;
      r_e       <= '0;
      r_carry   <= 1'b0;
      r_idx     <= '0;
      r_res     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if ((r_state == IDLE && in_valid) || r_state == RUN) begin
      if (r_state == IDLE) begin
        r_s      <= w_src_s;
        r_e      <= w_src_e;
        in_ready <= 1'b0;
      end
      r_res     <= w_next;
      r_carry   <= w_cout;
      r_idx     <= w_idx + 1'b1;
      r_state   <= w_fin ? DONE : RUN;
      out_valid <= w_fin;
      busy      <= !w_fin;
    end else if (r_state == DONE && out_ready) begin
      r_state   <= IDLE;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end
endmodule

// File: tb/tb_adlv_resolve.sv
// tb_adlv_resolve: directed self-checking bench for adlv_resolve
module tb_adlv_resolve;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [18:0] s_in = '0;
  logic [18:0] e_in = '0;
  logic        in_ready, out_valid, busy;
  logic [19:0] sum_out;
  int errors = 0;
  int checks = 0;
`ifdef ADLV_RESOLVE_BYPASS_EN
  localparam int BYP_LAT = 1;
`else
  localparam int BYP_LAT = 5;
`endif
  always #5 clk = ~clk;
  adlv_resolve dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .s_in(s_in), .e_in(e_in), .out_valid(out_valid), .out_ready(out_ready),
    .sum_out(sum_out), .busy(busy)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_txn(input logic [18:0] s, input logic [18:0] e, output int lat);
    s_in = s;
    e_in = e;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (sum_out !== 20'h0) begin errors++; $display("FAIL reset_sum got=%h exp=00000", sum_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
  endtask
  task automatic test_vectors();
    logic [18:0] vs [4] = '{19'h00001, 19'h7FFFF, 19'h0000F, 19'h2A5A5};
    logic [18:0] ve [4] = '{19'h00001, 19'h7FFFF, 19'h00001, 19'h15A5A};
    logic [19:0] vx [4] = '{20'h00002, 20'hFFFFE, 20'h00010, 20'h3FFFF};
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_txn(vs[i], ve[i], lat);
      checks++; if (lat !== 5) begin errors++; $display("FAIL vec%0d_latency got=%0d exp=5", i, lat); end
      checks++; if (sum_out !== vx[i]) begin errors++; $display("FAIL vec%0d_sum got=%h exp=%h", i, sum_out, vx[i]); end
      tick();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL vec%0d_release out_valid=%0b in_ready=%0b exp 0/1", i, out_valid, in_ready); end
    end
  endtask
  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    run_txn(19'h00ABC, 19'h00123, lat);
    checks++; if (lat !== 5 || sum_out !== 20'h00BDF) begin errors++; $display("FAIL bp_first lat=%0d sum=%h exp 5/00bdf", lat, sum_out); end
    s_in = 19'h11111;
    e_in = 19'h00001;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || sum_out !== 20'h00BDF || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d out_valid=%0b sum=%h in_ready=%0b exp 1/00bdf/0", i, out_valid, sum_out, in_ready);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum_out !== 20'h00BDF) begin
      errors++; $display("FAIL bp_release out_valid=%0b in_ready=%0b sum=%h exp 0/1/00bdf", out_valid, in_ready, sum_out);
    end
    tick();
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_ignored busy=%0b in_ready=%0b exp 0/1", busy, in_ready); end
  endtask
  task automatic test_reset_mid_run();
    int seen = 0;
    s_in = 19'h00001;
    e_in = 19'h00001;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL mid_run_busy busy=%0b in_ready=%0b exp 1/0", busy, in_ready); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum_out !== 20'h0) begin
      errors++; $display("FAIL mid_run_reset in_ready=%0b out_valid=%0b busy=%0b sum=%h exp 1/0/0/00000", in_ready, out_valid, busy, sum_out);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL mid_run_no_output valid_cycles=%0d exp=0", seen); end
  endtask
  task automatic test_bypass();
    int lat;
    out_ready = 1'b1;
    run_txn(19'h12345, 19'h00000, lat);
    checks++; if (lat !== BYP_LAT) begin errors++; $display("FAIL bypass_latency got=%0d exp=%0d", lat, BYP_LAT); end
    checks++; if (sum_out !== 20'h12345) begin errors++; $display("FAIL bypass_sum got=%h exp=12345", sum_out); end
    tick();
    run_txn(19'h12345, 19'h00001, lat);
    checks++; if (lat !== 5 || sum_out !== 20'h12346) begin errors++; $display("FAIL bypass_nonzero_e lat=%0d sum=%h exp 5/12346", lat, sum_out); end
    tick();
  endtask
  task automatic test_back_to_back();
    int rises [2];
    int n = 0;
    out_ready = 1'b1;
    s_in = 19'h00003;
    e_in = 19'h00004;
    in_valid = 1'b1;
    for (int cyc = 1; cyc <= 30 && n < 2; cyc++) begin
      tick();
      if (out_valid) begin
        rises[n] = cyc;
        checks++; if (sum_out !== 20'h00007) begin errors++; $display("FAIL b2b_sum%0d got=%h exp=00007", n, sum_out); end
        n++;
      end
    end
    in_valid = 1'b0;
    checks++; if (n !== 2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", n); end
    else begin
      checks++; if (rises[1] - rises[0] !== 6) begin errors++; $display("FAIL b2b_period got=%0d exp=6", rises[1] - rises[0]); end
    end
    tick();
    tick();
  endtask
  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid_run();
    test_bypass();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
